// File: rtl/complex_vector_addsub.sv
// Complex fixed-point add/subtract engine with run control, pipelined datapath and accumulate mode.
// Define CVADD_SAT_EN for saturating arithmetic; otherwise components wrap modulo 2^W.
module complex_vector_addsub #(
  parameter int unsigned W      = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              mode,
  input  logic              op,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*W-1:0]    a,
  input  logic [2*W-1:0]    b,
  output logic              out_valid,
  output logic [2*W-1:0]    result,
  output logic [2*W-1:0]    held,
  input  logic              hold_clr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LAST = STAGES - 1;
  localparam int unsigned DW   = 2 * W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // One component add/sub; subtraction folds into the adder as x + ~y + 1.
  function automatic logic [W-1:0] f_addsub(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic sub);
    logic [W-1:0] y_eff;
    logic [W-1:0] sum;
    y_eff = sub ? ~y : y;
    sum   = x + y_eff + W'(sub);
`ifdef CVADD_SAT_EN
    if ((x[W-1] == y_eff[W-1]) && (sum[W-1] != x[W-1]))
      sum = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return sum;
  endfunction

  function automatic logic [DW-1:0] f_cplx(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                           input logic sub);
    return {f_addsub(x[DW-1:W], y[DW-1:W], sub), f_addsub(x[W-1:0], y[W-1:0], sub)};
  endfunction

  state_t             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_in_cnt;
  logic               r_mode;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_done;
  logic [STAGES-1:0]  r_pv;
  logic [STAGES-1:0]  r_plast;
  logic [DW-1:0]      r_pd [STAGES];
  logic [DW-1:0]      r_acc;
  logic               r_acc_v;
  logic [DW-1:0]      r_held;

  logic               w_accept;
  logic               w_is_last;
  logic               w_enter_last;
  logic               w_fin;

  assign w_accept  = in_valid & r_in_ready;
  assign w_is_last = (r_in_cnt == r_len - LEN_W'(1));

  // Final element is about to enter the last pipeline stage on this edge.
  generate
    if (STAGES == 1) begin : g_one
      assign w_enter_last = w_accept & w_is_last;
    end else begin : g_multi
      assign w_enter_last = r_plast[STAGES-2];
    end
  endgenerate

  // The edge that makes the final out_valid visible.
  assign w_fin = r_mode ? r_plast[LAST] : w_enter_last;

  always_ff @(posedge clk or posedge rst) begin : p_fsm
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_mode     <= 1'b0;
      r_in_cnt   <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len    <= len;
            r_mode   <= mode;
            r_in_cnt <= '0;
            if (len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_RUN;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_in_cnt <= r_in_cnt + LEN_W'(1);
            if (w_is_last) begin
              r_in_ready <= 1'b0;
              if (w_fin) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (w_fin) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Add/sub pipeline: the first register captures the accepted element's result.
  always_ff @(posedge clk or posedge rst) begin : p_pipe
    if (rst) begin
      r_pv    <= '0;
      r_plast <= '0;
      for (int unsigned k = 0; k < STAGES; k++) r_pd[k] <= '0;
    end else begin
      r_pv[0]    <= w_accept;
      r_plast[0] <= w_accept & w_is_last;
      r_pd[0]    <= f_cplx(a, b, op);
      for (int unsigned k = 1; k < STAGES; k++) begin
        r_pv[k]    <= r_pv[k-1];
        r_plast[k] <= r_plast[k-1];
        r_pd[k]    <= r_pd[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_acc
    if (rst) begin
      r_acc   <= '0;
      r_acc_v <= 1'b0;
    end else begin
      r_acc_v <= r_mode & r_plast[LAST];
      if ((r_state == S_IDLE) && start)
        r_acc <= '0;
      else if (r_mode && r_pv[LAST])
        r_acc <= f_cplx(r_acc, r_pd[LAST], 1'b0);
    end
  end

  // A load of a presented result takes priority over the clear request.
  always_ff @(posedge clk or posedge rst) begin : p_held
    if (rst)
      r_held <= '0;
    else if (out_valid)
      r_held <= result;
    else if (hold_clr)
      r_held <= '0;
  end

  assign out_valid = r_mode ? r_acc_v : r_pv[LAST];
  assign result    = r_mode ? r_acc : r_pd[LAST];
  assign held      = r_held;
  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_complex_vector_addsub.sv
// Scoreboard bench for complex_vector_addsub: random and directed runs checked against an
// integer-arithmetic reference model; follows CVADD_SAT_EN the same way as the design.
module tb_complex_vector_addsub;

  localparam int W      = 16;
  localparam int STAGES = 2;
  localparam int LEN_W  = 8;
  localparam int DW     = 2 * W;
  localparam int MAXV   = (1 << (W - 1)) - 1;
  localparam int MINV   = -(1 << (W - 1));
`ifdef CVADD_SAT_EN
  localparam logic [DW-1:0] TP1_LAST = 32'h7FFF_0000;
`else
  localparam logic [DW-1:0] TP1_LAST = 32'h8000_0000;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             mode = 1'b0;
  logic             op = 1'b0;
  logic             in_valid = 1'b0;
  logic             hold_clr = 1'b0;
  logic [DW-1:0]    a = '0;
  logic [DW-1:0]    b = '0;
  logic             in_ready, out_valid, busy, done;
  logic [DW-1:0]    result, held;

  complex_vector_addsub #(.W(W), .STAGES(STAGES), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode), .op(op),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .result(result), .held(held), .hold_clr(hold_clr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DW-1:0] res;
    int            cyc;
    bit            fin;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] da[$];
  logic [DW-1:0] db[$];
  bit            dop[$];
  bit            dv[$];
  bit            fin_seen = 1'b0;
  bit            zero_ok  = 1'b0;
  bit            held_pend = 1'b0;
  logic [DW-1:0] last_res = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact signed integer arithmetic, then clamp or wrap to W bits.
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input bit sub);
    int v;
    v = sub ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
`ifdef CVADD_SAT_EN
    if (v > MAXV) v = MAXV;
    if (v < MINV) v = MINV;
`endif
    return W'(v);
  endfunction

  function automatic logic [DW-1:0] ref_cplx(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                             input bit sub);
    return {ref_op(x[DW-1:W], y[DW-1:W], sub), ref_op(x[W-1:0], y[W-1:0], sub)};
  endfunction

  function automatic logic [W-1:0] rnd_comp();
    case ($urandom_range(0, 5))
      0:       return {1'b0, {(W-1){1'b1}}};
      1:       return {1'b1, {(W-1){1'b0}}};
      2:       return {W{1'b1}};
      3:       return W'(1);
      default: return W'($urandom());
    endcase
  endfunction

  task automatic pick(output logic [DW-1:0] ea, output logic [DW-1:0] eb, output bit eop);
    ea  = (da.size() != 0) ? da.pop_front() : {rnd_comp(), rnd_comp()};
    eb  = (db.size() != 0) ? db.pop_front() : {rnd_comp(), rnd_comp()};
    eop = (dop.size() != 0) ? dop.pop_front() : bit'($urandom_range(0, 1));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin : p_mon
    exp_t e;
    if (rst) begin
      held_pend = 1'b0;
    end else begin
      if (held_pend) chk("held_load", held, last_res);
      held_pend = 1'b0;
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          e = sbq.pop_front();
          chk("result", result, e.res);
          chk("out_cycle", cyc, e.cyc);
          chk("done_with_out", done, e.fin);
          if (e.fin) fin_seen = 1'b1;
        end
        last_res  = result;
        held_pend = 1'b1;
      end else if (done && !zero_ok) begin
        chk("spurious_done", done, 0);
      end
    end
  end

  // One run; entered and left just after a rising edge with the DUT idle.
  task automatic do_run(input int n, input bit md, input int vpct, input bit start_mid,
                        input bit clr_hold, input bit rst_after);
    int            cnt;
    int            guard;
    bit            v;
    bit            eop;
    logic [DW-1:0] ea, eb, p, acc;
    exp_t          it;
    fin_seen = 1'b0;
    zero_ok  = (n == 0);
    start    = 1'b1;
    len      = LEN_W'(n);
    mode     = md;
    hold_clr = clr_hold;
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      @(negedge clk);
      chk("len0_done", done, 1);
      chk("len0_out_valid", out_valid, 0);
      chk("len0_busy", busy, 0);
      chk("len0_in_ready", in_ready, 0);
      @(negedge clk);
      chk("len0_done_after", done, 0);
      chk("len0_busy_after", busy, 0);
      zero_ok = 1'b0;
      @(posedge clk); #1;
      return;
    end
    acc = '0;
    cnt = 0;
    guard = 0;
    pick(ea, eb, eop);
    while (cnt < n && guard < 8 * n + 40) begin
      v = (dv.size() != 0) ? dv.pop_front() : ($urandom_range(1, 100) <= vpct);
      in_valid = v;
      a  = ea;
      b  = eb;
      op = eop;
      if (start_mid && cnt == 1) begin
        start = 1'b1;
        len   = LEN_W'(n + 3);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      chk("in_ready_run", in_ready, 1);
      chk("busy_run", busy, 1);
      if (v && in_ready) begin
        p = ref_cplx(ea, eb, eop);
        if (md) begin
          acc = ref_cplx(acc, p, 1'b0);
          if (cnt == n - 1) begin
            it.res = acc; it.cyc = (cyc + 1) + STAGES; it.fin = 1'b1;
            sbq.push_back(it);
          end
        end else begin
          it.res = p; it.cyc = (cyc + 1) + STAGES - 1; it.fin = (cnt == n - 1);
          sbq.push_back(it);
        end
        cnt++;
        if (cnt < n) pick(ea, eb, eop);
      end
      guard++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("accept_count", cnt, n);
    if (rst_after) begin
      rst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_held", held, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_done", done, 0);
      sbq.delete();
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk("no_out_after_rst", out_valid, 0);
      end
      @(posedge clk); #1;
      hold_clr = 1'b0;
      return;
    end
    @(negedge clk);
    chk("in_ready_after_last", in_ready, 0);
    #1;
    guard = 0;
    while (!fin_seen && guard < 40) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("run_finished", fin_seen, 1);
    chk("scoreboard_empty", sbq.size(), 0);
    @(negedge clk);
    chk("idle_done_low", done, 0);
    chk("idle_busy_low", busy, 0);
    chk("idle_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    hold_clr = 1'b0;
    if (clr_hold) begin
      @(negedge clk);
      chk("held_cleared_after_run", held, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_held", held, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Element-wise directed run including a real-part overflow.
    da  = '{{16'd1, 16'd2}, {16'hFFFB, 16'd0}, {16'h7FFF, 16'd0}};
    db  = '{{16'd3, 16'd4}, {16'd5, 16'd0}, {16'd1, 16'd0}};
    dop = '{1'b0, 1'b0, 1'b0};
    do_run(3, 1'b0, 100, 1'b0, 1'b0, 1'b0);
    chk("tp1_held", held, TP1_LAST);

    hold_clr = 1'b1;
    @(posedge clk); #1;
    hold_clr = 1'b0;
    @(negedge clk);
    chk("hold_clr_alone", held, 0);
    @(posedge clk); #1;

    // Accumulate: four times (10+10j)-(1+2j).
    for (int i = 0; i < 4; i++) begin
      da.push_back({16'd10, 16'd10});
      db.push_back({16'd1, 16'd2});
      dop.push_back(1'b1);
    end
    do_run(4, 1'b1, 100, 1'b0, 1'b0, 1'b0);
    chk("tp2_held", held, {16'd36, 16'd32});

    dv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_run(3, 1'b0, 100, 1'b0, 1'b0, 1'b0);

    do_run(0, 1'b0, 100, 1'b0, 1'b0, 1'b0);
    do_run(5, 1'b0, 70, 1'b1, 1'b0, 1'b0);
    do_run(4, 1'b0, 100, 1'b0, 1'b1, 1'b0);
    do_run(3, 1'b0, 100, 1'b0, 1'b0, 1'b1);
    do_run(4, 1'b0, 100, 1'b0, 1'b0, 1'b0);
    do_run(3, 1'b1, 60, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++)
      do_run(int'($urandom_range(1, 10)), bit'($urandom_range(0, 1)),
             int'($urandom_range(40, 100)), 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
